// File: rtl/kernel_pkg.sv
// Shared types and constants for the 3x3 kernel streamer.
package kernel_pkg;

    localparam int unsigned KERNEL_TAPS = 9;
    localparam int unsigned TAP_W       = 4;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    typedef logic [TAP_W-1:0] tap_t;

endpackage

// File: rtl/kernel_streamer_3x3_if.sv
// AXI-Stream channel carrying one kernel weight per beat.
interface kernel_streamer_3x3_if #(
    parameter int unsigned WIDTH = 8
);
    logic             o_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;

    modport master (output o_tvalid, output o_tdata, output o_tlast, input i_tready);
    modport slave  (input o_tvalid, input o_tdata, input o_tlast, output i_tready);

endinterface

// File: rtl/kernel_store_3x3.sv
// DEPTH x 9 x WIDTH weight registers: whole-kernel write port, per-tap combinational read.
module kernel_store_3x3
    import kernel_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_aclk,
    input  logic                       i_areset,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_sel,
    input  logic [9*WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_kernel,
    input  tap_t                       i_rd_tap,
    output logic [WIDTH-1:0]           o_rd_data_c
);

    logic [WIDTH-1:0] mem_q [DEPTH][KERNEL_TAPS];

    // Storage clears on reset; a write replaces all nine taps of one slot.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                for (int t = 0; t < int'(KERNEL_TAPS); t++) begin
                    mem_q[k][t] <= '0;
                end
            end
        end else if (i_wr_en) begin
            for (int t = 0; t < int'(KERNEL_TAPS); t++) begin
                mem_q[i_wr_sel][t] <= i_wr_data[t*int'(WIDTH) +: WIDTH];
            end
        end
    end

    always_comb begin
        o_rd_data_c = '0;
        if (i_rd_tap < tap_t'(KERNEL_TAPS)) begin
            o_rd_data_c = mem_q[i_rd_kernel][i_rd_tap];
        end
    end

endmodule

// File: rtl/kernel_streamer_3x3.sv
// Streams all stored 3x3 kernels, one weight per AXI-Stream beat, kernel 0 tap 00 first.
module kernel_streamer_3x3
    import kernel_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_aclk,
    input  logic                       i_areset,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_sel,
    input  logic [9*WIDTH-1:0]         i_wr_data,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    kernel_streamer_3x3_if.master      axis
);

    localparam int unsigned     SEL_W     = $clog2(DEPTH);
    localparam tap_t            LAST_TAP  = tap_t'(KERNEL_TAPS - 1);
    localparam logic [SEL_W-1:0] LAST_KERN = SEL_W'(DEPTH - 1);

    state_e             state_q, state_d;
    tap_t               tap_q, tap_d, nxt_tap_c, rd_tap_c;
    logic [SEL_W-1:0]   kern_q, kern_d, nxt_kern_c, rd_kern_c;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   tdata_q, tdata_d;
    logic [WIDTH-1:0]   rd_data_c;
    logic               store_wr_c;

    assign store_wr_c = i_wr_en && (state_q == IDLE);

    kernel_store_3x3 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .i_aclk      (i_aclk),
        .i_areset    (i_areset),
        .i_wr_en     (store_wr_c),
        .i_wr_sel    (i_wr_sel),
        .i_wr_data   (i_wr_data),
        .i_rd_kernel (rd_kern_c),
        .i_rd_tap    (rd_tap_c),
        .o_rd_data_c (rd_data_c)
    );

    // Position of the beat that follows the current one; both counters wrap.
    always_comb begin
        nxt_tap_c  = tap_q + tap_t'(1);
        nxt_kern_c = kern_q;
        if (tap_q == LAST_TAP) begin
            nxt_tap_c  = '0;
            nxt_kern_c = kern_q + SEL_W'(1);
        end
    end

    assign rd_tap_c  = (state_q == SEND) ? nxt_tap_c  : '0;
    assign rd_kern_c = (state_q == SEND) ? nxt_kern_c : '0;

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        kern_d   = kern_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tdata_d  = tdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = SEND;
                    tap_d    = '0;
                    kern_d   = '0;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    busy_d   = 1'b1;
                    // A same-cycle write to slot 0 must appear in the first beat.
                    tdata_d  = (i_wr_en && (i_wr_sel == '0)) ? i_wr_data[WIDTH-1:0] : rd_data_c;
                end
            end
            SEND: begin
                if (tvalid_q && axis.i_tready) begin
                    if (tlast_q) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        tdata_d  = '0;
                        tap_d    = '0;
                        kern_d   = '0;
                    end else begin
                        tap_d   = nxt_tap_c;
                        kern_d  = nxt_kern_c;
                        tdata_d = rd_data_c;
                        tlast_d = (nxt_kern_c == LAST_KERN) && (nxt_tap_c == LAST_TAP);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            kern_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            kern_q   <= kern_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tdata_q  <= tdata_d;
        end
    end

    assign axis.o_tvalid = tvalid_q;
    assign axis.o_tdata  = tdata_q;
    assign axis.o_tlast  = tlast_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_kernel_streamer_3x3.sv
// Randomized self-checking bench for kernel_streamer_3x3 against an array model of kernel storage.
module tb_kernel_streamer_3x3;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int          NTAPS  = 9;
    localparam int          NBEATS = NTAPS * int'(DEPTH);
    localparam int          BUDGET = 2000;

    logic                       i_aclk = 1'b0;
    logic                       i_areset;
    logic                       i_wr_en;
    logic [$clog2(DEPTH)-1:0]   i_wr_sel;
    logic [9*WIDTH-1:0]         i_wr_data;
    logic                       i_start;
    logic                       o_busy;
    logic                       o_done;

    kernel_streamer_3x3_if #(.WIDTH(WIDTH)) axis ();

    kernel_streamer_3x3 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_aclk    (i_aclk),
        .i_areset  (i_areset),
        .i_wr_en   (i_wr_en),
        .i_wr_sel  (i_wr_sel),
        .i_wr_data (i_wr_data),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .axis      (axis)
    );

    always #5 i_aclk = ~i_aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int ref_mem [DEPTH][NTAPS];
    int rx      [DEPTH][NTAPS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write one slot through the DUT port and record it in the model.
    task automatic wr_kernel(input int sel, input int taps [NTAPS]);
        i_wr_en  = 1'b1;
        i_wr_sel = ($clog2(DEPTH))'(sel);
        for (int t = 0; t < NTAPS; t++) begin
            i_wr_data[t*int'(WIDTH) +: WIDTH] = WIDTH'(taps[t]);
            ref_mem[sel][t] = taps[t] & 32'hFF;
        end
        @(negedge i_aclk);
        i_wr_en = 1'b0;
    endtask

    task automatic clear_model();
        for (int k = 0; k < int'(DEPTH); k++)
            for (int t = 0; t < NTAPS; t++)
                ref_mem[k][t] = 0;
    endtask

    // Receive one full stream (or abort it with reset) and check it against the model.
    task automatic run_stream(input bit rnd, input int inject_at, input int abort_at);
        int         exp_q[$];
        int         beats = 0;
        int         cyc = 0;
        bit         pv = 1'b0;
        bit         pr = 1'b0;
        logic [WIDTH-1:0] pd = '0;
        logic       pl = 1'b0;
        bit         injecting = 1'b0;
        bit         inj_done = 1'b0;
        bit         aborted = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++)
            for (int t = 0; t < NTAPS; t++)
                exp_q.push_back(ref_mem[k][t]);

        chk("start_busy", 32'(o_busy), 32'd1);
        chk("start_valid", 32'(axis.o_tvalid), 32'd1);
        while (beats < NBEATS && cyc < BUDGET) begin
            if (cyc > 0) chk("valid_held", 32'(axis.o_tvalid), 32'd1);
            if (pv && !pr) begin
                chk("stall_data", 32'(axis.o_tdata), 32'(pd));
                chk("stall_last", 32'(axis.o_tlast), 32'(pl));
            end
            axis.i_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (injecting) begin
                i_start   = 1'b0;
                i_wr_en   = 1'b0;
                injecting = 1'b0;
            end
            if (inject_at >= 0 && beats == inject_at && !inj_done) begin
                i_start   = 1'b1;
                i_wr_en   = 1'b1;
                i_wr_sel  = '0;
                i_wr_data = '1;
                injecting = 1'b1;
                inj_done  = 1'b1;
            end
            pv = axis.o_tvalid;
            pr = axis.i_tready;
            pd = axis.o_tdata;
            pl = axis.o_tlast;
            if (axis.o_tvalid && axis.i_tready) begin
                chk("beat_data", 32'(axis.o_tdata), 32'(exp_q[beats]));
                chk("beat_last", 32'(axis.o_tlast), 32'(beats == NBEATS - 1));
                rx[beats / NTAPS][beats % NTAPS] = int'(axis.o_tdata);
                beats++;
            end
            @(negedge i_aclk);
            cyc++;
            if (abort_at >= 0 && beats == abort_at) begin
                aborted  = 1'b1;
                i_areset = 1'b1;
                #1;
                chk("abort_valid", 32'(axis.o_tvalid), 32'd0);
                chk("abort_busy", 32'(o_busy), 32'd0);
                chk("abort_tdata", 32'(axis.o_tdata), 32'd0);
                chk("abort_done", 32'(o_done), 32'd0);
                repeat (3) @(negedge i_aclk);
                i_areset = 1'b0;
                clear_model();
                repeat (3) begin
                    @(negedge i_aclk);
                    chk("abort_no_done", 32'(o_done), 32'd0);
                end
                break;
            end
        end
        i_start = 1'b0;
        i_wr_en = 1'b0;
        if (!aborted) begin
            chk("beat_count", 32'(beats), 32'(NBEATS));
            chk("end_valid", 32'(axis.o_tvalid), 32'd0);
            chk("end_last", 32'(axis.o_tlast), 32'd0);
            chk("end_busy", 32'(o_busy), 32'd0);
            chk("end_done", 32'(o_done), 32'd1);
            @(negedge i_aclk);
            chk("done_pulse", 32'(o_done), 32'd0);
        end
        axis.i_tready = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle write) and run the stream.
    task automatic start_stream(input bit rnd, input int inject_at, input int abort_at);
        i_start = 1'b1;
        @(negedge i_aclk);
        i_start = 1'b0;
        i_wr_en = 1'b0;
        run_stream(rnd, inject_at, abort_at);
    endtask

    initial begin
        int taps [NTAPS];
        i_areset      = 1'b1;
        i_wr_en       = 1'b0;
        i_wr_sel      = '0;
        i_wr_data     = '0;
        i_start       = 1'b0;
        axis.i_tready = 1'b0;
        clear_model();
        repeat (2) @(negedge i_aclk);
        chk("rst_valid", 32'(axis.o_tvalid), 32'd0);
        chk("rst_last", 32'(axis.o_tlast), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_tdata", 32'(axis.o_tdata), 32'd0);
        i_areset = 1'b0;
        @(negedge i_aclk);

        // Slot k, tap t holds 9k+t+1.
        for (int k = 0; k < int'(DEPTH); k++) begin
            for (int t = 0; t < NTAPS; t++) taps[t] = NTAPS * k + t + 1;
            wr_kernel(k, taps);
        end

        start_stream(1'b0, -1, -1);
        for (int k = 0; k < int'(DEPTH); k++)
            for (int t = 0; t < NTAPS; t++)
                chk("rx_slot", 32'(rx[k][t]), 32'(NTAPS * k + t + 1));

        repeat (2) @(negedge i_aclk);
        start_stream(1'b1, -1, -1);

        repeat (2) @(negedge i_aclk);
        start_stream(1'b1, 30, -1);
        repeat (2) @(negedge i_aclk);
        start_stream(1'b1, -1, -1);

        repeat (2) @(negedge i_aclk);
        start_stream(1'b1, -1, 20);
        start_stream(1'b1, -1, -1);

        // Write slot 0 and start in the same cycle.
        repeat (2) @(negedge i_aclk);
        for (int t = 0; t < NTAPS; t++) taps[t] = 32'hA0 + t;
        i_start = 1'b1;
        wr_kernel(0, taps);
        i_start = 1'b0;
        run_stream(1'b1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
